// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 interrupt controller: Status/Cause/EPC/Count/Compare registers,
// source latching, and the request/acknowledge handshake that redirects fetch to the ISR.
module cp0_irq_ctrl #(
  parameter logic [31:0] ISR_VECTOR = 32'hC000_0000,
  parameter int          N_EXT      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       cp0_addr,
  input  logic             cp0_we,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  input  logic [N_EXT-1:0] ext_irq,
  output logic             irq_req,
  input  logic             irq_ack,
  input  logic [31:0]      restart_pc,
  output logic             isr_take,
  output logic [31:0]      isr_pc
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_TAKE
  } state_t;

  state_t           state_q, state_d;
  logic             ie_q, ie_d;
  logic [7:0]       im_q, im_d;
  logic [7:0]       ip_q, ip_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic [N_EXT-1:0] ext_prev_q, ext_prev_d;
  logic             irq_req_q, irq_req_d;
  logic             isr_take_q, isr_take_d;

  logic             wr_count, wr_compare, wr_status, wr_cause;
  logic             pending;
  logic             timer_hit;
  logic [N_EXT-1:0] ext_edge;
  logic [7:0]       ext_set;

  assign ext_edge = ext_irq & ~ext_prev_q;

  // Map external rising edges onto IP[10+i]; IP15 stays reserved for the timer.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ext_map
    if (gi >= 2 && gi < 7 && (gi - 2) < N_EXT) begin : g_src
      assign ext_set[gi] = ext_edge[gi-2];
    end else begin : g_none
      assign ext_set[gi] = 1'b0;
    end
  end

  assign pending   = (|(ip_q & im_q)) & ie_q;
  assign timer_hit = (count_q == compare_q);

  always_comb begin
    wr_count   = cp0_we && (cp0_addr == ADDR_COUNT);
    wr_compare = cp0_we && (cp0_addr == ADDR_COMPARE);
    wr_status  = cp0_we && (cp0_addr == ADDR_STATUS);
    wr_cause   = cp0_we && (cp0_addr == ADDR_CAUSE);

    // Set conditions override a software clear; a Compare write overrides the timer set.
    ip_d = wr_cause ? cp0_wdata[15:8] : ip_q;
    ip_d = ip_d | ext_set;
    if (timer_hit)  ip_d[7] = 1'b1;
    if (wr_compare) ip_d[7] = 1'b0;

    ie_d       = wr_status ? cp0_wdata[0]    : ie_q;
    im_d       = wr_status ? cp0_wdata[15:8] : im_q;
    epc_d      = epc_q;
    count_d    = wr_count ? cp0_wdata : count_q + 32'd1;
    compare_d  = wr_compare ? cp0_wdata : compare_q;
    ext_prev_d = ext_irq;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pending) state_d = ST_REQ;
      ST_REQ: begin
        if (irq_ack) begin
          epc_d   = restart_pc;
          ie_d    = 1'b0;
          state_d = ST_TAKE;
        end else if (!pending) begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    irq_req_d  = (state_d == ST_REQ);
    isr_take_d = (state_d == ST_TAKE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ie_q       <= 1'b0;
      im_q       <= 8'h00;
      ip_q       <= 8'h00;
      epc_q      <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'hFFFF_FFFF;
      ext_prev_q <= '0;
      irq_req_q  <= 1'b0;
      isr_take_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      ext_prev_q <= ext_prev_d;
      irq_req_q  <= irq_req_d;
      isr_take_q <= isr_take_d;
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    unique case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
      ADDR_STATUS:  cp0_rdata = {16'h0, im_q, 7'h0, ie_q};
      ADDR_CAUSE:   cp0_rdata = {16'h0, ip_q, 8'h0};
      ADDR_EPC:     cp0_rdata = epc_q;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  assign irq_req  = irq_req_q;
  assign isr_take = isr_take_q;
  assign isr_pc   = ISR_VECTOR;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed scenarios plus randomized traffic against a per-cycle behavioural model
// of the CP0 registers and interrupt handshake.
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cp0_addr = '0;
  logic        cp0_we = 1'b0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata;
  logic [4:0]  ext_irq = '0;
  logic        irq_req;
  logic        irq_ack = 1'b0;
  logic [31:0] restart_pc = '0;
  logic        isr_take;
  logic [31:0] isr_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference state, kept as plain architectural values.
  bit          m_ie;
  logic [7:0]  m_im, m_ip;
  logic [31:0] m_epc, m_count, m_compare;
  logic [4:0]  m_prev;
  int          m_phase;  // 0 idle, 1 requesting, 2 taking

  cp0_irq_ctrl #(.ISR_VECTOR(32'hC000_0000), .N_EXT(5)) dut (
    .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .cp0_we(cp0_we),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .ext_irq(ext_irq),
    .irq_req(irq_req), .irq_ack(irq_ack), .restart_pc(restart_pc),
    .isr_take(isr_take), .isr_pc(isr_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0, m_im, 7'h0, m_ie};
      5'd13:   return {16'h0, m_ip, 8'h0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ie = 0; m_im = 0; m_ip = 0; m_epc = 0; m_count = 0;
    m_compare = 32'hFFFF_FFFF; m_prev = 0; m_phase = 0;
  endtask

  // Advance model and DUT one clock, then compare the visible outputs.
  task automatic step();
    bit pend, hit, w_cnt, w_cmp, w_st, w_ca, ie_n;
    logic [7:0] ip_n, im_n;
    if (rst) begin
      model_reset();
    end else begin
      w_cnt = cp0_we && cp0_addr == 5'd9;
      w_cmp = cp0_we && cp0_addr == 5'd11;
      w_st  = cp0_we && cp0_addr == 5'd12;
      w_ca  = cp0_we && cp0_addr == 5'd13;
      pend  = ((m_ip & m_im) != 8'h00) && m_ie;
      hit   = (m_count == m_compare);
      ip_n  = w_ca ? cp0_wdata[15:8] : m_ip;
      ip_n  = ip_n | ({3'b000, ext_irq & ~m_prev} << 2);
      if (hit)   ip_n = ip_n | 8'h80;
      if (w_cmp) ip_n = ip_n & 8'h7F;
      ie_n = w_st ? cp0_wdata[0] : m_ie;
      im_n = w_st ? cp0_wdata[15:8] : m_im;
      if (m_phase == 0) begin
        if (pend) m_phase = 1;
      end else if (m_phase == 1) begin
        if (irq_ack) begin
          m_epc = restart_pc; ie_n = 0; m_phase = 2;
        end else if (!pend) m_phase = 0;
      end else m_phase = 0;
      m_ip = ip_n; m_ie = ie_n; m_im = im_n;
      m_count   = w_cnt ? cp0_wdata : m_count + 1;
      m_compare = w_cmp ? cp0_wdata : m_compare;
      m_prev    = ext_irq;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("irq_req", {31'b0, irq_req}, {31'b0, m_phase == 1});
    check("isr_take", {31'b0, isr_take}, {31'b0, m_phase == 2});
    check("rdata", cp0_rdata, model_read(cp0_addr));
    $display("cyc=%0d rst=%0b we=%0b addr=%0d wdata=%h ext=%b ack=%0b rdata=%h req=%0b take=%0b",
             cyc, rst, cp0_we, cp0_addr, cp0_wdata, ext_irq, irq_ack, cp0_rdata, irq_req, isr_take);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_addr = a; cp0_wdata = d;
    step();
    cp0_we = 0;
  endtask

  task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  logic [31:0] c;
  bit found;
  logic [4:0] addr_pool [8] = '{5'd3, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

  initial begin
    model_reset();
    // 1: timer interrupt and full take sequence
    rst = 1; step(); step();
    check("rst_req", {31'b0, irq_req}, 0);
    check("rst_take", {31'b0, isr_take}, 0);
    peek(11, "rst_compare", 32'hFFFF_FFFF);
    peek(13, "rst_cause", 0);
    peek(9, "rst_count", 0);
    check("isr_pc", isr_pc, 32'hC000_0000);
    rst = 0;
    wr(11, 5);
    wr(12, 32'h8001);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cp0_addr = 13; step();
      if (cp0_rdata[15]) found = 1;
    end
    check("ip15_seen", {31'b0, found}, 1);
    peek(9, "count_at_ip15", 6);
    check("req_before", {31'b0, irq_req}, 0);
    step();
    check("req_after_ip15", {31'b0, irq_req}, 1);
    irq_ack = 1; restart_pc = 32'h40;
    step();
    irq_ack = 0;
    check("take_pulse", {31'b0, isr_take}, 1);
    peek(14, "epc_40", 32'h40);
    peek(12, "status_ie_clr", 32'h8000);
    for (int i = 0; i < 3; i++) begin
      step(); check("take_once", {31'b0, isr_take}, 0);
    end

    // 2: external source edge, software clear with level held high
    wr(13, 0);
    wr(12, 32'h0801);
    ext_irq = 5'b00010;
    step();
    peek(13, "cause_0800", 32'h0800);
    step();
    check("ext_req", {31'b0, irq_req}, 1);
    wr(13, 0);
    step();
    check("ext_req_drop", {31'b0, irq_req}, 0);
    for (int i = 0; i < 4; i++) begin
      step(); check("level_no_reset", {31'b0, irq_req}, 0);
    end
    peek(13, "cause_stays_0", 0);

    // 3: set beats clear; Compare write beats timer match
    ext_irq = 0; step();
    ext_irq = 5'b00010; cp0_we = 1; cp0_addr = 13; cp0_wdata = 0;
    step();
    cp0_we = 0;
    peek(13, "edge_beats_clr", 32'h0800);
    wr(12, 0);
    wr(13, 0);
    step(); step();
    c = m_count;
    wr(11, c + 3);
    step(); step();
    peek(9, "count_eq_cmp", c + 3);
    wr(11, 0);
    step();
    peek(13, "cmp_wr_beats_hit", 0);

    // 4: mask before acknowledge abandons the request
    wr(13, 32'h0100);
    wr(12, 32'h0101);
    step();
    check("sw_req", {31'b0, irq_req}, 1);
    wr(12, 0);
    step();
    check("req_abandon", {31'b0, irq_req}, 0);
    irq_ack = 1; restart_pc = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      step(); check("no_take", {31'b0, isr_take}, 0);
    end
    irq_ack = 0;
    peek(14, "epc_unchanged", 32'h40);

    // 5: Count wrap and unmapped read
    wr(9, 32'hFFFF_FFFF);
    peek(9, "count_ffff", 32'hFFFF_FFFF);
    step();
    peek(9, "count_wrap", 0);
    peek(3, "unmapped", 0);

    // 6: reset while requesting
    wr(13, 32'h0200);
    wr(12, 32'h0201);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(); if (irq_req) found = 1;
    end
    check("req_before_rst", {31'b0, found}, 1);
    rst = 1; step(); rst = 0;
    check("rst_req_drop", {31'b0, irq_req}, 0);
    peek(13, "rst_cause_0", 0);
    peek(11, "rst_cmp_ff", 32'hFFFF_FFFF);
    peek(12, "rst_status_0", 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cp0_we = ($urandom_range(0, 2) == 0);
      cp0_addr = addr_pool[$urandom_range(0, 7)];
      cp0_wdata = $urandom;
      if (cp0_addr == 11) cp0_wdata = m_count + $urandom_range(1, 12);
      if (cp0_addr == 12 && $urandom_range(0, 3) != 0) cp0_wdata[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) ext_irq[$urandom_range(0, 4)] ^= 1'b1;
      irq_ack = ($urandom_range(0, 2) == 0);
      restart_pc = $urandom;
      step();
    end
    rst = 0; cp0_we = 0; irq_ack = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
